// File: rtl/ternary_perf_counters.sv
// Purpose: saturating performance counters (cycles, retires, stalls, forwards, retire-width histogram) with shadow bank.
// Latency: counters update at the edge after an active cycle; read port returns data 1 cycle after rd_sel/rd_src.
// Backpressure: none; observe-only block, every input is sampled each cycle and nothing is ever stalled.
module ternary_perf_counters #(
  parameter int ISSUE_WIDTH = 2,
  parameter int CNT_WIDTH   = 32,
  localparam int NUM_CNT    = 6 + ISSUE_WIDTH,
  localparam int SEL_W      = $clog2(6 + ISSUE_WIDTH)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   cnt_en,
  input  logic                   clr,
  input  logic                   halted,
  input  logic [ISSUE_WIDTH-1:0] retire_valid,
  input  logic                   stall,
  input  logic [ISSUE_WIDTH-1:0] fwd_valid,
  input  logic                   snap,
  input  logic [SEL_W-1:0]       rd_sel,
  input  logic                   rd_src,
  output logic [CNT_WIDTH-1:0]   rd_data,
  output logic                   rd_ovf,
  output logic                   ovf_any,
  output logic                   counting
);

  // Counter slots: 0 CYCLES, 1 INSTRET, 2 STALLS, 3 FWD_CYC, 4 FWD_OPS, 5+k HIST[k].
  localparam int HIST_BASE = 5;

  logic                                  active;
  logic [2:0]                            ret_cnt;
  logic [2:0]                            fwd_cnt;
  logic [NUM_CNT-1:0][2:0]               inc;
  logic [NUM_CNT-1:0][CNT_WIDTH-1:0]     live_q, live_d;
  logic [NUM_CNT-1:0][CNT_WIDTH-1:0]     shad_q, shad_d;
  logic [NUM_CNT-1:0]                    ovf_q, ovf_d;
  logic [NUM_CNT-1:0]                    shad_ovf_q, shad_ovf_d;
  logic [CNT_WIDTH+2:0]                  sum;
  logic [CNT_WIDTH-1:0]                  rd_data_d;
  logic                                  rd_ovf_d;

  // clr wins over counting, so it also suppresses the active flag.
  assign active  = cnt_en & ~halted & ~clr;
  assign ovf_any = |ovf_q;

  // Per-cycle retire and forward popcounts; a stalled cycle retires nothing.
  always_comb begin
    ret_cnt = '0;
    fwd_cnt = '0;
    for (int i = 0; i < ISSUE_WIDTH; i++) begin
      ret_cnt = ret_cnt + {2'b00, retire_valid[i]};
      fwd_cnt = fwd_cnt + {2'b00, fwd_valid[i]};
    end
    if (stall) ret_cnt = '0;
  end

  // Increment applied to each counter slot on an active cycle.
  always_comb begin
    inc    = '0;
    inc[0] = 3'd1;
    inc[1] = ret_cnt;
    inc[2] = {2'b00, stall};
    inc[3] = {2'b00, |fwd_valid};
    inc[4] = fwd_cnt;
    for (int k = 0; k <= ISSUE_WIDTH; k++) begin
      inc[HIST_BASE+k] = {2'b00, ret_cnt == 3'(k)};
    end
  end

  // Live bank next state: clear, or widened add that clamps to all-ones and flags overflow.
  always_comb begin
    live_d = live_q;
    ovf_d  = ovf_q;
    sum    = '0;
    if (clr) begin
      live_d = '0;
      ovf_d  = '0;
    end else if (active) begin
      for (int i = 0; i < NUM_CNT; i++) begin
        sum = {3'b000, live_q[i]} + {{CNT_WIDTH{1'b0}}, inc[i]};
        if (sum[CNT_WIDTH+2:CNT_WIDTH] != 3'b000) begin
          live_d[i] = '1;
          ovf_d[i]  = 1'b1;
        end else begin
          live_d[i] = sum[CNT_WIDTH-1:0];
        end
      end
    end
  end

  // Shadow captures the live bank as it stood before this edge's update.
  always_comb begin
    shad_d     = shad_q;
    shad_ovf_d = shad_ovf_q;
    if (snap) begin
      shad_d     = live_q;
      shad_ovf_d = ovf_q;
    end
  end

  // Read mux looks at post-update bank state so the registered result matches the edge it was sampled on.
  always_comb begin
    rd_data_d = '0;
    rd_ovf_d  = 1'b0;
    if (int'(rd_sel) < NUM_CNT) begin
      rd_data_d = rd_src ? shad_d[rd_sel]     : live_d[rd_sel];
      rd_ovf_d  = rd_src ? shad_ovf_d[rd_sel] : ovf_d[rd_sel];
    end
  end

  // State registers; reset discards both banks and the read port entirely.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      live_q     <= '0;
      ovf_q      <= '0;
      shad_q     <= '0;
      shad_ovf_q <= '0;
      rd_data    <= '0;
      rd_ovf     <= 1'b0;
      counting   <= 1'b0;
    end else begin
      live_q     <= live_d;
      ovf_q      <= ovf_d;
      shad_q     <= shad_d;
      shad_ovf_q <= shad_ovf_d;
      rd_data    <= rd_data_d;
      rd_ovf     <= rd_ovf_d;
      counting   <= active;
    end
  end

endmodule
